// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request feeding a 2-entry {instruction, pc} queue.
// Optional `FETCH_MISALIGN_CHECK_EN adds fetch_misaligned and stalls on unaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_misaligned,
`endif
  input  logic        id_ready,
  input  logic        redirect_trap,
  input  logic [31:0] trap_target,
  input  logic        redirect_mret,
  input  logic [31:0] mret_target,
  input  logic        redirect_branch,
  input  logic [31:0] branch_target
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q;
  logic [31:0] last_pc_q;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q;
  logic        push, pop, redirect, misaligned_q;
  logic [31:0] redirect_raw, redirect_aligned;

  assign redirect         = redirect_trap | redirect_mret | redirect_branch;
  assign redirect_raw     = redirect_trap ? trap_target :
                            redirect_mret ? mret_target : branch_target;
  assign redirect_aligned = redirect_raw & ~32'h3;

  assign instr_valid = (count_q != 2'd0);
  assign instruction = instr_valid ? q_instr[rd_ptr_q] : BUBBLE_INSTR;
  assign pc          = instr_valid ? q_pc[rd_ptr_q] : last_pc_q;
  assign pop         = instr_valid & id_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = 1'b0;
    imem_addr  = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        // Occupancy alone gates issue: nothing is outstanding while in FETCH.
        imem_req = (count_q != 2'd2) & ~misaligned_q;
        if (imem_req) begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = FETCH;
        end
      end
      DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) state_d = FETCH;
      end
    endcase
    // A redirect drops any returning word; an unacked request must still drain in DISCARD.
    if (redirect) begin
      push       = 1'b0;
      fetch_pc_d = redirect_aligned;
      if (state_d == WAIT) state_d = DISCARD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      last_pc_q  <= RESET_PC;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      if (imem_req) req_addr_q <= imem_addr;
      if (push) last_pc_q <= imem_addr;
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
        count_q  <= 2'd0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect && (redirect_raw[1:0] != 2'b00)) last_pc_q <= redirect_raw;
`endif
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]    <= imem_addr;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        misaligned_q <= 1'b0;
    else if (redirect) misaligned_q <= (redirect_raw[1:0] != 2'b00);
  end
  assign fetch_misaligned = misaligned_q;
`else
  assign misaligned_q = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {instruction, pc}, a negedge monitor pops on each decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_ack, instr_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, instruction, pc;
  logic        redirect_trap, redirect_mret, redirect_branch;
  logic [31:0] trap_target, mret_target, branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_fails  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misaligned(fetch_misaligned),
`endif
    .id_ready(id_ready),
    .redirect_trap(redirect_trap), .trap_target(trap_target),
    .redirect_mret(redirect_mret), .mret_target(mret_target),
    .redirect_branch(redirect_branch), .branch_target(branch_target)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [31:0] a);
    check("imem_req", {31'b0, imem_req}, 32'd1);
    check("imem_addr", imem_addr, a);
    imem_ack   = 1'b1;
    imem_rdata = mem(a);
    sb.push_back('{instr: mem(a), pc: a});
    cyc();
  endtask

  task automatic clear_redirects();
    redirect_trap   = 1'b0;
    redirect_mret   = 1'b0;
    redirect_branch = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && id_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected no valid entry", pc, instruction);
      end else begin
        entry_t e;
        e = sb.pop_front();
        check("head_instr", instruction, e.instr);
        check("head_pc", pc, e.pc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; id_ready = 1'b1;
    trap_target = '0; mret_target = '0; branch_target = '0;
    clear_redirects();
    repeat (3) cyc();
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instruction", instruction, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);

    // Release with ack already high: the IDLE cycle must ignore it.
    rst_n = 1'b1;
    cyc();
    check("idle_valid", {31'b0, instr_valid}, 32'd0);
    ack_word(32'h0);
    check("first_valid", {31'b0, instr_valid}, 32'd1);
    check("first_pc", pc, 32'h0);
    ack_word(32'h4);
    ack_word(32'h8);
    ack_word(32'hC);

    // Outstanding request to 0x10, branch away, late ack dropped.
    imem_ack = 1'b0;
    check("wait_addr", imem_addr, 32'h10);
    cyc();
    redirect_branch = 1'b1; branch_target = 32'h40;
    cyc();
    clear_redirects(); sb.delete();
    check("discard_valid", {31'b0, instr_valid}, 32'd0);
    check("discard_req", {31'b0, imem_req}, 32'd1);
    check("discard_addr", imem_addr, 32'h10);
    cyc();
    check("discard_addr2", imem_addr, 32'h10);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    check("after_discard_valid", {31'b0, instr_valid}, 32'd0);
    ack_word(32'h40);
    ack_word(32'h44);

    // Trap beats branch in the same cycle as an ack.
    check("pre_trap_addr", imem_addr, 32'h48);
    redirect_trap = 1'b1; trap_target = 32'h100;
    redirect_branch = 1'b1; branch_target = 32'h200;
    imem_rdata = mem(32'h48);
    cyc();
    clear_redirects(); sb.delete();
    check("trap_flush_valid", {31'b0, instr_valid}, 32'd0);
    check("trap_flush_pc", pc, 32'h44);
    ack_word(32'h100);

    // Mret beats branch.
    redirect_mret = 1'b1; mret_target = 32'h300;
    redirect_branch = 1'b1; branch_target = 32'h500;
    cyc();
    clear_redirects(); sb.delete();
    check("mret_addr", imem_addr, 32'h300);

    redirect_branch = 1'b1; branch_target = 32'h42;
    cyc();
    clear_redirects(); sb.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misaligned_flag", {31'b0, fetch_misaligned}, 32'd1);
    check("misaligned_req", {31'b0, imem_req}, 32'd0);
    check("misaligned_pc", pc, 32'h42);
    cyc();
    check("misaligned_hold", {31'b0, imem_req}, 32'd0);
    redirect_branch = 1'b1; branch_target = 32'h80;
    cyc();
    clear_redirects();
    check("misaligned_clear", {31'b0, fetch_misaligned}, 32'd0);
    ack_word(32'h80);
`else
    ack_word(32'h40);
`endif

    // Address wrap at the top of the space.
    redirect_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc();
    clear_redirects(); sb.delete();
    ack_word(32'hFFFF_FFFC);
    ack_word(32'h0);

    // Reset mid-request, then back-pressure with ack tied high.
    imem_ack = 1'b0;
    cyc();
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; id_ready = 1'b0;
    repeat (2) cyc();
    sb.delete();
    check("rst2_req", {31'b0, imem_req}, 32'd0);
    check("rst2_valid", {31'b0, instr_valid}, 32'd0);
    rst_n = 1'b1;
    cyc();
    check("idle2_valid", {31'b0, instr_valid}, 32'd0);
    ack_word(32'h0);
    ack_word(32'h4);
    check("full_req", {31'b0, imem_req}, 32'd0);
    check("full_valid", {31'b0, instr_valid}, 32'd1);
    check("full_pc", pc, 32'h0);
    cyc();
    check("full_req_hold", {31'b0, imem_req}, 32'd0);
    check("full_instr", instruction, mem(32'h0));
    id_ready = 1'b1;
    cyc();
    ack_word(32'h8);
    ack_word(32'hC);
    imem_ack = 1'b0;
    repeat (3) cyc();
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUBBLE_INSTR, default 32'h0000_0013 (addi x0,x0,0): instruction driven when no valid entry.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory request; held until imem_ack.
REQ-006 imem_addr  output  32  word-aligned fetch address; stable while imem_req high.
REQ-007 imem_ack  input  1  response valid this cycle; completes the outstanding request.
REQ-008 imem_rdata  input  32  fetched word; sampled only when imem_ack is high.
REQ-009 instruction  output  32  head-of-queue instruction to decoder.
REQ-010 instr_valid  output  1  instruction and pc are valid.
REQ-011 pc  output  32  address of instruction.
REQ-012 id_ready  input  1  decode stage accepts head this cycle (pop when instr_valid && id_ready).
REQ-013 redirect_trap / trap_target  input  1 / 32  jump to trap vector.
REQ-014 redirect_mret / mret_target  input  1 / 32  return to mepc.
REQ-015 redirect_branch / branch_target  input  1 / 32  taken branch/jump target.

Function
REQ-016 Fetch queue SHALL be 2 entries, each holding {instruction, pc}; FIFO order.
REQ-017 At most one memory request SHALL be outstanding; imem_req SHALL assert only when queue occupancy plus outstanding requests < 2.
REQ-018 States: IDLE, FETCH, WAIT, DISCARD; reset enters IDLE; IDLE -> FETCH unconditionally next cycle.
REQ-019 FETCH: imem_req=1 with imem_addr=fetch_pc when space exists, moving to WAIT; FETCH with full queue holds imem_req=0.
REQ-020 imem_ack in the same cycle imem_req first asserts SHALL be honoured (zero-wait memory); with ack, next request MAY issue the following cycle, giving one word per cycle sustained throughput.
REQ-021 On accepted ack (no redirect): push {imem_rdata, fetch_pc}, fetch_pc += 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), return to FETCH.
REQ-022 Empty queue: instr_valid=0, instruction=BUBBLE_INSTR, pc=last pushed pc value (or RESET_PC after reset); no bypass: pushed word is visible the cycle after ack.
REQ-023 Redirect priority: trap > mret > branch; selected target loaded into fetch_pc on the redirect cycle.
REQ-024 Any redirect SHALL flush the queue; instr_valid=0 the following cycle; flush overrides a simultaneous pop or push.
REQ-025 Redirect while a request is outstanding and not acked that cycle: enter DISCARD, keep imem_req/imem_addr unchanged until ack, drop that data, then FETCH from new target.
REQ-026 Redirect in the same cycle as ack: data dropped, next state FETCH with new target.
REQ-027 Redirect during DISCARD: update fetch_pc to newest target, remain in DISCARD.
REQ-028 Push and pop in the same cycle on a non-empty queue SHALL keep occupancy unchanged; pop when empty is impossible by construction.
REQ-029 Redirect target bits [1:0] SHALL be forced to 0 for imem_addr unless REQ-034 applies.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, instr_valid=0, instruction=BUBBLE_INSTR, pc=RESET_PC.
REQ-031 Reset asserted mid-request SHALL abandon the request; an imem_ack arriving in IDLE SHALL be ignored.
REQ-032 Reset overrides all redirect and handshake inputs.

Configuration
REQ-033 Macro FETCH_MISALIGN_CHECK_EN selects target alignment checking.
REQ-034 Defined: adds output fetch_misaligned (1 bit); a redirect with target[1:0]!=0 flushes, holds imem_req=0, and asserts fetch_misaligned until the next redirect or reset; pc output = unaligned target.
REQ-035 Undefined: no fetch_misaligned port; low target bits silently cleared per REQ-029.

Verification
REQ-036 Reset release, imem_ack tied 1, id_ready=1 -> imem_addr 0,4,8,... one per cycle; instr_valid first high 2 cycles after rst_n rises, pc=0.
REQ-037 id_ready=0 with ack always 1 -> exactly 2 words queued (pc 0,4), imem_req low; id_ready=1 -> pops pc 0 then 4 in order, fetching resumes at 8.
REQ-038 Request to 0x10 outstanding, redirect_branch to 0x40, ack 3 cycles later with 0xDEAD_BEEF -> word dropped, next imem_addr=0x40, no instr_valid with pc 0x10.
REQ-039 redirect_trap(0x100) and redirect_branch(0x200) same cycle as ack -> next imem_addr=0x100, queue empty next cycle.
REQ-040 fetch_pc=0xFFFF_FFFC, ack -> next imem_addr=0x0000_0000.
REQ-041 With FETCH_MISALIGN_CHECK_EN, redirect_branch to 0x42 -> fetch_misaligned=1, imem_req=0; redirect to 0x80 clears it and fetches 0x80.
